// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline-stage buffer.
//   pipe_state_e : buffer FSM state (EMPTY, ONE, TWO), 2-bit encoding
//   PIPE_LANES / PIPE_LANE_W / PIPE_CTRL_W : default widths
//   OCC_W        : width of the occupancy output
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_LANES  = 4;
  localparam int unsigned PIPE_LANE_W = 32;
  localparam int unsigned PIPE_CTRL_W = 24;
  localparam int unsigned OCC_W       = 2;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload register of the stage buffer (vf, ctrl, data).
// Ports:
//   clk, rst            clock, asynchronous active-low reset (clears payload)
//   load                capture vf_d/ctrl_d/data_d on this edge
//   vf_d, ctrl_d, data_d  payload to store; scalar beats (vf_d=0) have lanes
//                       1..LANES-1 stored as zero, lane 0 unchanged
//   vf_q, ctrl_q, data_q  stored payload
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned LANES  = PIPE_LANES,
  parameter int unsigned LANE_W = PIPE_LANE_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      vf_d,
  input  logic [CTRL_W-1:0]         ctrl_d,
  input  logic [LANES*LANE_W-1:0]   data_d,
  output logic                      vf_q,
  output logic [CTRL_W-1:0]         ctrl_q,
  output logic [LANES*LANE_W-1:0]   data_q
);

  logic [LANES*LANE_W-1:0] data_st;

  assign data_st[LANE_W-1:0] = data_d[LANE_W-1:0];

  for (genvar g = 1; g < LANES; g++) begin : g_lane
    assign data_st[g*LANE_W +: LANE_W] = vf_d ? data_d[g*LANE_W +: LANE_W] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vf_q   <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else if (load) begin
      vf_q   <= vf_d;
      ctrl_q <= ctrl_d;
      data_q <= data_st;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register with a 2-entry skid buffer.
// Optional feature macro: PIPE_STAGE_STATS_EN (adds stall_cnt port/counter).
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   flush                 synchronous kill of all held beats
//   in_valid/in_ready     upstream handshake
//   in_vf/in_ctrl/in_data upstream beat (vf=0 scalar: upper lanes zeroed)
//   out_valid/out_ready   downstream handshake
//   out_vf/out_ctrl/out_data presented beat (MAIN slot)
//   occupancy             beats held, 0..2
//   stall_cnt             (PIPE_STAGE_STATS_EN) saturating count of cycles
//                         with out_valid=1 and out_ready=0
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned LANES  = PIPE_LANES,
  parameter int unsigned LANE_W = PIPE_LANE_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_vf,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [LANES*LANE_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_vf,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic [OCC_W-1:0]          occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  pipe_state_e state_q, state_d;

  logic in_fire, out_fire;
  logic main_load, main_from_skid, skid_load;

  logic                    skid_vf;
  logic [CTRL_W-1:0]       skid_ctrl;
  logic [LANES*LANE_W-1:0] skid_data;

  logic                    main_vf_d;
  logic [CTRL_W-1:0]       main_ctrl_d;
  logic [LANES*LANE_W-1:0] main_data_d;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    occupancy = '0;
    case (state_q)
      ONE:     occupancy = OCC_W'(1);
      TWO:     occupancy = OCC_W'(2);
      default: occupancy = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Flush only clears validity; payload slots keep stale contents.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // SKID data is already lane-zeroed; re-applying zeroing on transfer is idempotent.
  always_comb begin
    main_vf_d   = in_vf;
    main_ctrl_d = in_ctrl;
    main_data_d = in_data;
    if (main_from_skid) begin
      main_vf_d   = skid_vf;
      main_ctrl_d = skid_ctrl;
      main_data_d = skid_data;
    end
  end

  pipe_slot #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .vf_d   (main_vf_d),
    .ctrl_d (main_ctrl_d),
    .data_d (main_data_d),
    .vf_q   (out_vf),
    .ctrl_q (out_ctrl),
    .data_q (out_data)
  );

  pipe_slot #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .vf_d   (in_vf),
    .ctrl_d (in_ctrl),
    .data_d (in_data),
    .vf_q   (skid_vf),
    .ctrl_q (skid_ctrl),
    .data_q (skid_data)
  );

`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 32;
  localparam int unsigned CTRL_W = 24;
  localparam int unsigned DW     = LANES * LANE_W;

  typedef struct {
    logic              vf;
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_vf;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_vf;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DW-1:0]     out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       exp_stall = '0;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  beat_t       q[$];
  logic        exp_rdy = 1'b1;
  logic        mon_en  = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vf     (in_vf),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vf    (out_vf),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a scalar beat keeps only lane 0, zero-extended.
  function automatic beat_t mk(input logic vf, input logic [CTRL_W-1:0] c, input logic [DW-1:0] d);
    beat_t b;
    logic [LANE_W-1:0] lane0;
    lane0  = d[LANE_W-1:0];
    b.vf   = vf;
    b.ctrl = c;
    b.data = vf ? d : DW'(lane0);
    return b;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d = '0;
    for (int w = 0; w < int'(DW / 32); w++) d = (d << 32) | DW'($urandom);
    return d;
  endfunction

  // Monitor: samples mid-cycle, compares presented beat with queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", DW'(in_ready), DW'(q.size() < 2));
      chk("occupancy", DW'(occupancy), DW'(q.size()));
      chk("out_valid", DW'(out_valid), DW'(q.size() != 0));
`ifdef PIPE_STAGE_STATS_EN
      chk("stall_cnt", DW'(stall_cnt), DW'(exp_stall));
      if (q.size() != 0 && !out_ready && exp_stall != '1) exp_stall = exp_stall + 32'd1;
`endif
      exp_rdy = (q.size() < 2);
      if (q.size() != 0 && out_valid) begin
        chk("out_vf", DW'(out_vf), DW'(q[0].vf));
        chk("out_ctrl", DW'(out_ctrl), DW'(q[0].ctrl));
        chk("out_data", out_data, q[0].data);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Stimulus: on the clock edge, record what the model accepts, then
  // let the caller drive new inputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      if (flush) q.delete();
      else if (in_valid && exp_rdy) q.push_back(mk(in_vf, in_ctrl, in_data));
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic vf, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_vf    = vf;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    #1 rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_in_ready", DW'(in_ready), DW'(1'b1));
    chk("rst_out_valid", DW'(out_valid), DW'(1'b0));
    chk("rst_occupancy", DW'(occupancy), DW'(0));
    chk("rst_out_ctrl", DW'(out_ctrl), DW'(0));
    chk("rst_out_data", out_data, DW'(0));
    chk("rst_out_vf", DW'(out_vf), DW'(1'b0));
    step();
    rst = 1'b1;
    mon_en = 1'b1;

    // Stream with out_ready=1
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, CTRL_W'(i), 1'b1, rnd_data());
      step();
    end
    drive(1'b0, '0, 1'b0, '0);
    repeat (2) step();

    // Backpressure: A, B absorbed, C held upstream
    out_ready = 1'b0;
    drive(1'b1, CTRL_W'(24'hA), 1'b1, rnd_data()); step();
    drive(1'b1, CTRL_W'(24'hB), 1'b1, rnd_data()); step();
    drive(1'b1, CTRL_W'(24'hC), 1'b1, rnd_data()); step(); step();
    out_ready = 1'b1;
    step(); step();
    drive(1'b0, '0, 1'b0, '0);
    repeat (3) step();

    // Flush while TWO with a beat offered
    out_ready = 1'b0;
    drive(1'b1, CTRL_W'(24'h10), 1'b1, rnd_data()); step();
    drive(1'b1, CTRL_W'(24'h11), 1'b0, rnd_data()); step();
    drive(1'b1, CTRL_W'(24'hD), 1'b1, rnd_data());
    flush = 1'b1; step();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    chk("flush_out_valid", DW'(out_valid), DW'(1'b0));
    chk("flush_occupancy", DW'(occupancy), DW'(0));
    out_ready = 1'b1;
    repeat (3) step();

    // Scalar zeroing and vector pass-through
    drive(1'b1, CTRL_W'(24'h20), 1'b0, '1); step();
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    chk("scalar_zero", out_data, {96'h0, 32'hFFFF_FFFF});
    step();
    drive(1'b1, CTRL_W'(24'h21), 1'b1, '1); step();
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    chk("vector_keep", out_data, '1);
    step();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      drive(1'($urandom_range(0, 1)), CTRL_W'($urandom), 1'($urandom_range(0, 1)), rnd_data());
      out_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 99) < 3);
      step();
    end
    flush = 1'b0;

    // Async reset with two beats held, no clock edge
    out_ready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    drive(1'b1, CTRL_W'(24'h40), 1'b1, rnd_data()); step();
    drive(1'b1, CTRL_W'(24'h41), 1'b1, rnd_data()); step();
    drive(1'b0, '0, 1'b0, '0);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", DW'(out_valid), DW'(1'b0));
    chk("arst_occupancy", DW'(occupancy), DW'(0));
    chk("arst_in_ready", DW'(in_ready), DW'(1'b1));
    q.delete();
`ifdef PIPE_STAGE_STATS_EN
    exp_stall = '0;
`endif
    step();
    rst = 1'b1;
    mon_en = 1'b1;

`ifdef PIPE_STAGE_STATS_EN
    drive(1'b1, CTRL_W'(24'h30), 1'b1, rnd_data()); step();
    drive(1'b0, '0, 1'b0, '0);
    repeat (7) step();
    @(negedge clk);
    chk("stall_7", DW'(stall_cnt), DW'(32'd7));
    out_ready = 1'b1;
    flush = 1'b1; step(); flush = 1'b0;
    @(negedge clk);
    chk("stall_after_flush", DW'(stall_cnt), DW'(32'd7));
`endif

    // Drain with a bounded budget
    drive(1'b0, '0, 1'b0, '0);
    out_ready = 1'b1;
    for (int n = 0; n < 10 && q.size() != 0; n++) step();
    step();
    chk("drain_empty", DW'(q.size()), DW'(0));
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage register for the vector ASIP datapath, the successor of the fixed-width stage latches between EX and MEM. It carries one control word, a vector/scalar flag and a LANES×LANE_W operand bundle per beat. It adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush for taken jumps, and scalar-lane zeroing. It is instantiated once per stage boundary (ID/EX, EX/MEM, MEM/WB), with widths set per boundary.

## Interface
Parameters:
- LANES, 4, number of vector lanes (≥1)
- LANE_W, 32, bits per lane
- CTRL_W, 24, packed control-word width (rmem, wmem, wreg, CondEn, jmpF, ALUIns, ExtnSel, register tags …)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held beats (jump taken)
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_vf  in  1  1 = vector beat, 0 = scalar beat
- in_ctrl  in  CTRL_W  control word
- in_data  in  LANES*LANE_W  operand bundle, lane 0 in LSBs
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts
- out_vf  out  1  flag of presented beat
- out_ctrl  out  CTRL_W  control of presented beat
- out_data  out  LANES*LANE_W  operands of presented beat
- occupancy  out  2  beats held (0..2)
- stall_cnt  out  32  present only with PIPE_STAGE_STATS_EN

## Operation
- Two payload slots: MAIN drives out_*, SKID catches a beat accepted while MAIN is blocked.
- FSM states: EMPTY, ONE (MAIN valid), TWO (MAIN and SKID valid).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != TWO); out_valid = (state != EMPTY); occupancy = 0/1/2 per state.
- EMPTY: in_fire → MAIN ← input, go to ONE.
- ONE: in_fire & out_fire → MAIN ← input, stay ONE. in_fire only → SKID ← input, go to TWO. out_fire only → EMPTY.
- TWO: out_fire → MAIN ← SKID, go to ONE. No input is accepted.
- flush has priority over everything: next state EMPTY. A beat offered in the flush cycle is discarded even though in_ready is high. Payload registers keep their stale contents; only validity is cleared.
- Scalar zeroing: on any load with in_vf=0, lanes 1..LANES-1 are stored as 0 and lane 0 is stored unchanged. With in_vf=1 all lanes are stored unchanged. ctrl and vf are always stored as given.
- When LANES=1, scalar zeroing is a no-op.

## Timing
- Reset (rst low, asynchronous) puts the FSM in EMPTY and clears out_vf, out_ctrl, out_data and stall_cnt to 0. As a result, in_ready=1, out_valid=0 and occupancy=0.
- Latency from EMPTY is 1 cycle: a beat accepted at edge N appears on out_* after edge N.
- Sustained throughput is 1 beat/cycle while out_ready=1.
- Backpressure: out_ready may drop at any time. At most one extra beat is absorbed, then in_ready falls in the following cycle.
- out_* is stable while out_valid=1 and out_ready=0.
- Order is strictly FIFO. No beat is duplicated or lost except by flush.
- If rst is asserted mid-transfer, held beats are dropped. There is no partial beat.

## Configuration
- PIPE_STAGE_STATS_EN defined: stall_cnt is a 32-bit counter that increments every cycle with out_valid=1 and out_ready=0. It saturates at 0xFFFFFFFF, is not cleared by flush, and is cleared only by rst.
- PIPE_STAGE_STATS_EN undefined: the stall_cnt port and its counter are absent. All other behaviour is identical.

## Structure
- Package pipe_pkg holds:
  - the state enum (EMPTY, ONE, TWO), 2-bit encoding;
  - default constants PIPE_LANES, PIPE_LANE_W, PIPE_CTRL_W;
  - the occupancy width.
- Sub-module pipe_slot: one payload register (vf, ctrl, data) with load enable and scalar lane zeroing, parametrised like the parent. It is instantiated twice, as MAIN and SKID.
- The parent holds only the FSM, the handshake logic, the MAIN source mux (input or SKID) and the optional counter.

## Test plan
- Reset then stream: rst low 3 cycles, then feed ctrl=0x000001..0x000005 with out_ready=1. Expect out_ctrl 0x000001..0x000005 on 5 consecutive cycles, each 1 cycle after acceptance, with occupancy ≤1.
- Backpressure: hold out_ready=0 while feeding 0xA, 0xB, 0xC. Expect 0xA and 0xB accepted, in_ready=0 with occupancy=2, 0xC held upstream. Then raise out_ready: expect 0xA, 0xB, 0xC in order.
- Flush in TWO: with 2 beats held, pulse flush while in_valid=1 with 0xD. Next cycle expect out_valid=0 and occupancy=0; 0xD never appears at the output.
- Scalar zeroing (LANES=4): in_vf=0 with in_data lanes all 0xFFFFFFFF. Expect out_data=0x00000000_00000000_00000000_FFFFFFFF. With in_vf=1, expect the data unchanged.
- Async reset mid-stream: drop rst between clock edges while occupancy=2. Expect out_valid=0 and occupancy=0 immediately, with no clock needed.
- Stats (PIPE_STAGE_STATS_EN): hold 1 beat with out_ready=0 for 7 cycles. Expect stall_cnt=7. A following flush leaves stall_cnt at 7.
